// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
  localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
  localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
  localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
  localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    GAP        = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// scanning upward modulo N. Produces one-hot and index forms of the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
// Optional start timeout in WAIT_START: define UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [2:0]                     baud_sel_in,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           Tx_EN,
  output logic                           Tx_WR,
  output logic [UART_DATA_W-1:0]         Tx_DATA,
  output logic [2:0]                     baud_sel,
  input  logic                           Tx_BUSY,
  output logic                           sched_busy,
  output logic [15:0]                    frames_sent,
  output logic                           start_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t             state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            win_q, win_d;
  logic [NUM_REQ-1:0]       win_oh_q, win_oh_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     tx_en_q, tx_en_d;
  logic                     tx_wr_q, tx_wr_d;
  logic [UART_DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [2:0]               baud_q, baud_d;
  logic                     sbusy_q, sbusy_d;
  logic [15:0]              frames_q, frames_d;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_valid;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Outputs lag the FSM by one cycle: ISSUE produces the Tx_WR/grant pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    win_oh_d  = win_oh_q;
    grant_d   = '0;
    tx_wr_d   = 1'b0;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    baud_d    = baud_q;
    frames_d  = frames_q;
`ifdef UART_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        tx_en_d = en;
        baud_d  = baud_sel_in;
        if (en && arb_valid && !Tx_BUSY) begin
          state_d   = ISSUE;
          win_d     = arb_idx;
          win_oh_d  = arb_gnt;
          tx_data_d = req_data[int'(arb_idx)*UART_DATA_W +: UART_DATA_W];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tx_wr_d = 1'b1;
        grant_d = win_oh_q;
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d = WAIT_START;
`ifdef UART_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT_START: begin
        if (Tx_BUSY) begin
          state_d = WAIT_END;
`ifdef UART_SCHED_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(START_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
`else
        end else begin
          state_d = WAIT_START;
`endif
        end
      end
      WAIT_END: begin
        if (!Tx_BUSY) begin
          frames_d = frames_q + 16'd1;
          state_d  = GAP;
        end else begin
          state_d  = WAIT_END;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sbusy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      win_oh_q  <= '0;
      grant_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      baud_q    <= BAUD_SEL_9600;
      sbusy_q   <= 1'b0;
      frames_q  <= 16'd0;
`ifdef UART_SCHED_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      win_oh_q  <= win_oh_d;
      grant_q   <= grant_d;
      tx_en_q   <= tx_en_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      baud_q    <= baud_d;
      sbusy_q   <= sbusy_d;
      frames_q  <= frames_d;
`ifdef UART_SCHED_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign Tx_EN       = tx_en_q;
  assign Tx_WR       = tx_wr_q;
  assign Tx_DATA     = tx_data_q;
  assign baud_sel    = baud_q;
  assign sched_busy  = sbusy_q;
  assign frames_sent = frames_q;
`ifdef UART_SCHED_TIMEOUT_EN
  assign start_err   = err_q;
`else
  assign start_err   = 1'b0;
`endif

endmodule
